// File: rtl/girl_pkg.sv
// rtl/girl_pkg.sv - shared types, constants and sprite ROM contents for girl_sprite_fetch
package girl_pkg;

    typedef enum logic [1:0] {
        STAND = 2'd0,
        RUN   = 2'd1,
        AIR   = 2'd2
    } anim_state_t;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    localparam int         H_MAX           = 640;
    localparam int         V_MAX           = 480;

    // Sprite ROM image: a fixed nibble pattern over the 12-bit address space,
    // with index 0 appearing regularly so transparency is exercised.
    function automatic logic [3:0] rom_word(input logic [11:0] a);
        return a[3:0] ^ {a[6:4], a[7]} ^ a[11:8];
    endfunction

endpackage

// File: rtl/girl_rom.sv
// rtl/girl_rom.sv - synchronous single-port sprite ROM, 4-bit data, 1-cycle read latency
module girl_rom
    import girl_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [3:0]    data_o
);

    logic [3:0] data_q;

    // Registered read: address at cycle n gives data at cycle n+1.
    always_ff @(posedge clk) begin
        data_q <= rom_word(12'(addr_i));
    end

    assign data_o = data_q;

endmodule

// File: rtl/girl_sprite_fetch.sv
// rtl/girl_sprite_fetch.sv - Watergirl bounding box, ROM fetch and animation FSM (mirroring under GIRL_SPRITE_MIRROR_EN)
module girl_sprite_fetch
    import girl_pkg::*;
#(
    parameter int SPRITE_W  = 24,
    parameter int SPRITE_H  = 32,
    parameter int N_RUN     = 4,
    parameter int FRAME_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vsync,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] GirlX,
    input  logic [9:0] GirlY,
    input  logic       moving,
    input  logic       airborne,
    input  logic       facing_left,
    output logic [3:0] index,
    output logic       girl_on,
    output logic [2:0] anim_frame
);

    localparam int AW = $clog2((N_RUN + 1) * SPRITE_H * SPRITE_W);
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic              vs_q, vs_prev_q;
    logic              vs_rise;
    logic [9:0]        gx_s_q, gy_s_q;
    anim_state_t       state_q, state_d;
    logic [2:0]        frame_q, frame_d;
    logic [DW-1:0]     div_q, div_d;
    logic [10:0]       dx, dy, lx;
    logic              in_box_d;
    logic [AW-1:0]     addr_d;
    logic              in_box_s1_q, in_box_s2_q;
    logic [AW-1:0]     addr_s1_q;
    logic [3:0]        rom_data;

    assign vs_rise = vs_q & ~vs_prev_q;

    // vsync history for rising-edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_q      <= vsync;
            vs_prev_q <= vs_q;
        end
    end

    // Shadow position, latched once per frame so the sprite never tears
    always_ff @(posedge Clk) begin
        if (Reset) begin
            gx_s_q <= '0;
            gy_s_q <= '0;
        end else if (vs_rise) begin
            gx_s_q <= GirlX;
            gy_s_q <= GirlY;
        end
    end

`ifdef GIRL_SPRITE_MIRROR_EN
    logic face_s_q;

    // Shadow facing direction, latched with the position
    always_ff @(posedge Clk) begin
        if (Reset) begin
            face_s_q <= 1'b0;
        end else if (vs_rise) begin
            face_s_q <= facing_left;
        end
    end
`else
    logic unused_facing;
    assign unused_facing = facing_left;
`endif

    // Animation state, frame and divider registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= STAND;
            frame_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            div_q   <= div_d;
        end
    end

    // Animation next state: only moves on vs_rise; entering RUN wins over a divider step
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        div_d   = div_q;
        if (vs_rise) begin
            if (airborne) begin
                state_d = AIR;
            end else if (moving) begin
                state_d = RUN;
            end else begin
                state_d = STAND;
            end
            case (state_d)
                RUN: begin
                    if (state_q != RUN) begin
                        frame_d = '0;
                        div_d   = '0;
                    end else if (div_q == DW'(FRAME_DIV - 1)) begin
                        div_d   = '0;
                        frame_d = (frame_q == 3'(N_RUN - 1)) ? 3'd0 : frame_q + 3'd1;
                    end else begin
                        div_d   = div_q + DW'(1);
                    end
                end
                AIR: begin
                    frame_d = 3'(N_RUN);
                    div_d   = '0;
                end
                default: begin
                    frame_d = '0;
                    div_d   = '0;
                end
            endcase
        end
    end

    // Box test and ROM address; 11-bit zero-extended subtraction makes off-edge pixels clip
    always_comb begin
        dx       = {1'b0, DrawX} - {1'b0, gx_s_q};
        dy       = {1'b0, DrawY} - {1'b0, gy_s_q};
        in_box_d = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
`ifdef GIRL_SPRITE_MIRROR_EN
        lx       = face_s_q ? (11'(SPRITE_W - 1) - dx) : dx;
`else
        lx       = dx;
`endif
        addr_d   = (AW'(frame_q) * AW'(SPRITE_H) + AW'(dy)) * AW'(SPRITE_W) + AW'(lx);
    end

    // Pipeline: stage 1 holds box flag and address, stage 2 aligns the flag with ROM data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_box_s1_q <= 1'b0;
            addr_s1_q   <= '0;
            in_box_s2_q <= 1'b0;
        end else begin
            in_box_s1_q <= in_box_d;
            addr_s1_q   <= addr_d;
            in_box_s2_q <= in_box_s1_q;
        end
    end

    girl_rom #(
        .AW(AW)
    ) u_rom (
        .clk    (Clk),
        .addr_i (addr_s1_q),
        .data_o (rom_data)
    );

    assign index      = in_box_s2_q ? rom_data : TRANSPARENT_IDX;
    assign girl_on    = in_box_s2_q && (rom_data != TRANSPARENT_IDX);
    assign anim_frame = frame_q;

endmodule
